// File: rtl/aes_sbox_share_arb_if.sv
// rtl/aes_sbox_share_arb_if.sv - request, mux-select and result handshake bundle for the shared S-box arbiter
interface aes_sbox_share_arb_if;
    logic       ke_req;
    logic       dp_req;
    logic       sbox_src_sel;
    logic [1:0] col_sel;
    logic       sbox_issue;
    logic       dp_wr_en;
    logic [1:0] dp_wr_col;
    logic       ke_wr_en;
    logic       dp_done;
    logic       ke_done;
    logic       busy;
    logic       proto_err;

    modport master (
        output ke_req, dp_req,
        input  sbox_src_sel, col_sel, sbox_issue, dp_wr_en, dp_wr_col,
        input  ke_wr_en, dp_done, ke_done, busy, proto_err
    );

    modport slave (
        input  ke_req, dp_req,
        output sbox_src_sel, col_sel, sbox_issue, dp_wr_en, dp_wr_col,
        output ke_wr_en, dp_done, ke_done, busy, proto_err
    );
endinterface

// File: rtl/aes_sbox_share_arb.sv
// rtl/aes_sbox_share_arb.sv - arbiter/sequencer for the shared 32-bit S-box (optional AES_SBOX_ARB_PROTO_CHECK_EN)
module aes_sbox_share_arb #(
    parameter int SBOX_LAT     = 2,
    parameter bit KEY_PRIORITY = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    aes_sbox_share_arb_if.slave bus
);

    typedef enum logic [1:0] {IDLE, KE_ISSUE, DP_ISSUE, DRAIN} state_t;

    state_t     state;
    state_t     state_nx;
    logic       owner_ke;
    logic       last_ke;
    logic [1:0] cnt;
    logic       grant_ke;
    logic       grant_dp;

    logic       issue;
    logic       src;
    logic [1:0] col;

    logic [SBOX_LAT-1:0] pipe_vld;
    logic [SBOX_LAT-1:0] pipe_ke;
    logic [1:0]          pipe_col [SBOX_LAT];

    logic       ret_vld;
    logic       ret_ke;
    logic [1:0] ret_col;
    logic       ret_last;

    // Round-robin: with both pending, KE wins unless it was the last one served.
    assign grant_ke = bus.ke_req && (!bus.dp_req || KEY_PRIORITY || !last_ke);
    assign grant_dp = bus.dp_req && !grant_ke;

    assign ret_vld  = pipe_vld[SBOX_LAT-1];
    assign ret_ke   = pipe_ke[SBOX_LAT-1];
    assign ret_col  = pipe_col[SBOX_LAT-1];
    assign ret_last = ret_vld && (ret_ke || (ret_col == 2'd3));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_ke <= 1'b0;
            last_ke  <= 1'b0;
            cnt      <= 2'd0;
        end else if (state == IDLE) begin
            cnt <= 2'd0;
            if (grant_ke || grant_dp) begin
                owner_ke <= grant_ke;
                last_ke  <= grant_ke;
            end
        end else if (state == DP_ISSUE) begin
            cnt <= cnt + 2'd1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (grant_ke) begin
                    state_nx = KE_ISSUE;
                end else if (grant_dp) begin
                    state_nx = DP_ISSUE;
                end
            end
            KE_ISSUE: state_nx = DRAIN;
            DP_ISSUE: begin
                if (cnt == 2'd3) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (ret_last) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        issue = 1'b0;
        src   = 1'b0;
        col   = 2'd0;
        case (state)
            KE_ISSUE: begin
                issue = 1'b1;
                src   = 1'b1;
            end
            DP_ISSUE: begin
                issue = 1'b1;
                col   = cnt;
            end
            DRAIN:   src = owner_ke;
            default: src = 1'b0;
        endcase

        bus.sbox_issue   = issue;
        bus.sbox_src_sel = src;
        bus.col_sel      = col;
        bus.busy         = (state != IDLE);
        bus.dp_wr_en     = ret_vld && !ret_ke;
        bus.dp_wr_col    = (ret_vld && !ret_ke) ? ret_col : 2'd0;
        bus.ke_wr_en     = ret_vld && ret_ke;
        bus.dp_done      = (state == DRAIN) && ret_last && !ret_ke;
        bus.ke_done      = (state == DRAIN) && ret_last && ret_ke;
    end

    // Return pipe mirrors the S-box latency so write enables line up with results.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SBOX_LAT; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_ke[i]  <= 1'b0;
                pipe_col[i] <= 2'd0;
            end
        end else begin
            pipe_vld[0] <= issue;
            pipe_ke[0]  <= src;
            pipe_col[0] <= col;
            for (int i = 1; i < SBOX_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_ke[i]  <= pipe_ke[i-1];
                pipe_col[i] <= pipe_col[i-1];
            end
        end
    end

`ifdef AES_SBOX_ARB_PROTO_CHECK_EN
    logic err_q;
    logic owner_req;

    // A low owner request anywhere in the op, including its done cycle, is a violation.
    assign owner_req = owner_ke ? bus.ke_req : bus.dp_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((state != IDLE) && !owner_req) begin
            err_q <= 1'b1;
        end
    end

    assign bus.proto_err = err_q;
`else
    assign bus.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_sbox_share_arb.sv
// tb/tb_aes_sbox_share_arb.sv - scoreboard bench for aes_sbox_share_arb across latency/priority builds
module tb_aes_sbox_share_arb;

`ifdef AES_SBOX_ARB_PROTO_CHECK_EN
    localparam logic PE = 1'b1;
`else
    localparam logic PE = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic       owner;
        logic [1:0] col;
    } ev_t;

    typedef struct {
        int   cyc;
        int   kind;
        logic val;
    } st_t;

    localparam int ST_BUSY = 0;
    localparam int ST_PERR = 1;
    localparam int ST_ZERO = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   final_chk = 1'b0;
    bit   final_done = 1'b0;

    ev_t q_iss  [3][$];
    ev_t q_wr   [3][$];
    ev_t q_done [3][$];
    st_t q_st   [3][$];

    aes_sbox_share_arb_if ifa ();
    aes_sbox_share_arb_if ifb ();
    aes_sbox_share_arb_if ifc ();

    aes_sbox_share_arb #(.SBOX_LAT(2), .KEY_PRIORITY(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    aes_sbox_share_arb #(.SBOX_LAT(1), .KEY_PRIORITY(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
    aes_sbox_share_arb #(.SBOX_LAT(3), .KEY_PRIORITY(1'b1)) dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int id, input int got, input int req, input int req_cyc);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: got %0d, required %0d at cyc %0d", name, id, cyc, got, req, req_cyc);
        end
    endtask

    task automatic mon(input int id, input logic iss, input logic src, input logic [1:0] col,
                       input logic dpw, input logic [1:0] dpc, input logic kew,
                       input logic dpd, input logic ked, input logic bsy, input logic perr);
        ev_t e;
        st_t s;
        if (iss === 1'b1) begin
            if (q_iss[id].size() == 0) chk(1'b0, "issue_unexpected", id, {src, col}, 0, -1);
            else begin
                e = q_iss[id].pop_front();
                chk(e.cyc == cyc && e.owner == src && e.col == col, "issue", id, {src, col}, {e.owner, e.col}, e.cyc);
            end
        end
        if (dpw === 1'b1 || kew === 1'b1) begin
            if (q_wr[id].size() == 0) chk(1'b0, "wr_unexpected", id, {kew, dpc}, 0, -1);
            else begin
                e = q_wr[id].pop_front();
                chk(e.cyc == cyc && e.owner == kew && dpw == !kew && (kew || e.col == dpc),
                    "wr_en", id, {kew, dpc}, {e.owner, e.col}, e.cyc);
            end
        end
        if (dpd === 1'b1 || ked === 1'b1) begin
            if (q_done[id].size() == 0) chk(1'b0, "done_unexpected", id, {ked, dpd}, 0, -1);
            else begin
                e = q_done[id].pop_front();
                chk(e.cyc == cyc && e.owner == ked && dpd == !ked, "done", id, {ked, dpd}, {e.owner, !e.owner}, e.cyc);
            end
        end
        while (q_st[id].size() > 0 && q_st[id][0].cyc <= cyc) begin
            s = q_st[id].pop_front();
            case (s.kind)
                ST_BUSY: chk(s.cyc == cyc && bsy === s.val, "busy", id, int'(bsy), int'(s.val), s.cyc);
                ST_PERR: chk(s.cyc == cyc && perr === s.val, "proto_err", id, int'(perr), int'(s.val), s.cyc);
                default: chk(s.cyc == cyc && {iss, src, col, dpw, dpc, kew, dpd, ked, bsy, perr} === 12'd0,
                             "outputs_zero", id, {iss, src, col, dpw, dpc, kew, dpd, ked, bsy, perr}, 0, s.cyc);
            endcase
        end
    endtask

    always @(negedge clk) begin
        mon(0, ifa.sbox_issue, ifa.sbox_src_sel, ifa.col_sel, ifa.dp_wr_en, ifa.dp_wr_col, ifa.ke_wr_en,
            ifa.dp_done, ifa.ke_done, ifa.busy, ifa.proto_err);
        mon(1, ifb.sbox_issue, ifb.sbox_src_sel, ifb.col_sel, ifb.dp_wr_en, ifb.dp_wr_col, ifb.ke_wr_en,
            ifb.dp_done, ifb.ke_done, ifb.busy, ifb.proto_err);
        mon(2, ifc.sbox_issue, ifc.sbox_src_sel, ifc.col_sel, ifc.dp_wr_en, ifc.dp_wr_col, ifc.ke_wr_en,
            ifc.dp_done, ifc.ke_done, ifc.busy, ifc.proto_err);
        if (final_chk && !final_done) begin
            final_done <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                chk(q_iss[i].size() + q_wr[i].size() + q_done[i].size() + q_st[i].size() == 0,
                    "pending_expectations", i, q_iss[i].size() + q_wr[i].size() + q_done[i].size() + q_st[i].size(), 0, cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int id, input int kind, input int c, input logic owner, input logic [1:0] col);
        ev_t e;
        e.cyc = c; e.owner = owner; e.col = col;
        case (kind)
            0:       q_iss[id].push_back(e);
            1:       q_wr[id].push_back(e);
            default: q_done[id].push_back(e);
        endcase
    endtask

    task automatic push_st(input int id, input int kind, input int c, input logic val);
        st_t s;
        s.cyc = c; s.kind = kind; s.val = val;
        q_st[id].push_back(s);
    endtask

    // Expected events for one op first seen in IDLE at cycle 'start'.
    task automatic push_op(input int id, input int start, input logic ke, input int lat);
        if (ke) begin
            push_ev(id, 0, start + 1, 1'b1, 2'd0);
            push_ev(id, 1, start + 1 + lat, 1'b1, 2'd0);
            push_ev(id, 2, start + 1 + lat, 1'b1, 2'd0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                push_ev(id, 0, start + 1 + i, 1'b0, 2'(i));
                push_ev(id, 1, start + 1 + i + lat, 1'b0, 2'(i));
            end
            push_ev(id, 2, start + 4 + lat, 1'b0, 2'd0);
        end
    endtask

    initial begin
        int c;
        ifa.ke_req = 1'b0; ifa.dp_req = 1'b0;
        ifb.ke_req = 1'b0; ifb.dp_req = 1'b0;
        ifc.ke_req = 1'b0; ifc.dp_req = 1'b0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) push_st(i, ST_ZERO, cyc, 1'b0);
        step(2);

        // Datapath SubBytes alone, latency 2
        c = cyc;
        ifa.dp_req = 1'b1;
        push_op(0, c, 1'b0, 2);
        push_st(0, ST_BUSY, c + 1, 1'b1);
        push_st(0, ST_BUSY, c + 6, 1'b1);
        push_st(0, ST_BUSY, c + 7, 1'b0);
        step(7);
        ifa.dp_req = 1'b0;
        step(2);

        // Key SubWord alone
        c = cyc;
        ifa.ke_req = 1'b1;
        push_op(0, c, 1'b1, 2);
        push_st(0, ST_BUSY, c + 3, 1'b1);
        push_st(0, ST_BUSY, c + 4, 1'b0);
        step(4);
        ifa.ke_req = 1'b0;
        step(2);

        // Simultaneous requests with key priority
        c = cyc;
        ifa.ke_req = 1'b1;
        ifa.dp_req = 1'b1;
        push_op(0, c, 1'b1, 2);
        push_op(0, c + 4, 1'b0, 2);
        step(4);
        ifa.ke_req = 1'b0;
        step(7);
        ifa.dp_req = 1'b0;
        step(2);

        // Round-robin, latency 1, both requesters keep asking
        c = cyc;
        ifb.ke_req = 1'b1;
        ifb.dp_req = 1'b1;
        push_op(1, c, 1'b1, 1);
        push_op(1, c + 3, 1'b0, 1);
        push_op(1, c + 9, 1'b1, 1);
        push_op(1, c + 12, 1'b0, 1);
        push_st(1, ST_BUSY, c + 3, 1'b0);
        push_st(1, ST_BUSY, c + 9, 1'b0);
        push_st(1, ST_BUSY, c + 12, 1'b0);
        step(12);
        ifb.ke_req = 1'b0;
        step(6);
        ifb.dp_req = 1'b0;
        step(2);

        // Reset mid-op at latency 3, then a clean restart from column 0
        c = cyc;
        ifc.dp_req = 1'b1;
        for (int i = 0; i < 3; i++) push_ev(2, 0, c + 1 + i, 1'b0, 2'(i));
        step(3);
        reset = 1'b1;
        ifc.dp_req = 1'b0;
        step(1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) push_st(i, ST_ZERO, cyc, 1'b0);
        ifc.dp_req = 1'b1;
        push_op(2, cyc, 1'b0, 3);
        step(8);
        ifc.dp_req = 1'b0;
        step(2);

        // Request dropped mid-op: op completes, proto_err tracks the build option
        c = cyc;
        ifa.dp_req = 1'b1;
        push_op(0, c, 1'b0, 2);
        push_st(0, ST_PERR, c + 2, 1'b0);
        push_st(0, ST_PERR, c + 3, PE);
        push_st(0, ST_PERR, c + 7, PE);
        step(2);
        ifa.dp_req = 1'b0;
        step(5);
        ifa.ke_req = 1'b1;
        push_op(0, cyc, 1'b1, 2);
        push_st(0, ST_PERR, cyc + 4, PE);
        step(4);
        ifa.ke_req = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        push_st(0, ST_ZERO, cyc, 1'b0);
        step(3);

        final_chk = 1'b1;
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_sbox_share_arb.md
Name: aes_sbox_share_arb

Overview:
Arbiter and sequencer for the single shared 32-bit S-box (SubWord) unit. Two requesters use it: key expansion (one SubWord per request) and the round datapath (SubBytes on all four state columns per request). The block drives the shared mux selects: the 2:1 32-bit source mux and the 4:1 32-bit column mux. It issues S-box operations and tracks their return through a fixed-latency pipe so it can raise per-column write enables and completion pulses.

Parameters:
SBOX_LAT, 2, cycles from sbox_issue to result valid; legal range 1..4
KEY_PRIORITY, 1, 1 = key expansion wins simultaneous requests; 0 = round-robin between requesters

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
ke_req  in  1  key-expansion request for one SubWord; held high until ke_done
dp_req  in  1  datapath request for a 4-column SubBytes; held high until dp_done
sbox_src_sel  out  1  source mux select: 0 = datapath column, 1 = key word
col_sel  out  2  column mux select, column 0..3
sbox_issue  out  1  operand valid into the S-box this cycle
dp_wr_en  out  1  S-box result is a datapath column; write it back
dp_wr_col  out  2  column index for dp_wr_en
ke_wr_en  out  1  S-box result is the key SubWord
dp_done  out  1  one-cycle pulse: datapath operation complete
ke_done  out  1  one-cycle pulse: key operation complete
busy  out  1  high whenever state is not IDLE
proto_err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset (sync, active-high) forces IDLE and clears the return pipe, the round-robin pointer and proto_err. All outputs read 0 in the cycle after reset is sampled.
- Reset mid-operation aborts the operation. No wr_en or done is emitted for it. The next request starts again from column 0.
- States: IDLE, KE_ISSUE, DP_ISSUE, DRAIN.
- IDLE: arbitration happens here only; there is no preemption.
  - Only ke_req high -> KE_ISSUE.
  - Only dp_req high -> DP_ISSUE.
  - Both high -> KEY_PRIORITY=1 grants KE. KEY_PRIORITY=0 grants the requester not served last; the pointer resets to "last = DP", so KE goes first.
- KE_ISSUE (1 cycle): sbox_issue=1, sbox_src_sel=1, col_sel=0. Next state DRAIN.
- DP_ISSUE (4 cycles): sbox_issue=1, sbox_src_sel=0, col_sel counts 0,1,2,3. On count 3 -> DRAIN.
- DRAIN: sbox_issue=0; sbox_src_sel holds the owner. Stays until the return pipe has emitted the last result.
  - That final result cycle asserts the done pulse together with the last wr_en.
  - The next state is IDLE.
- Return pipe: SBOX_LAT-deep shift register of {valid, owner, col}. Its output drives dp_wr_en/dp_wr_col/ke_wr_en combinationally, so a result appears exactly SBOX_LAT cycles after its issue.
- Timing, request first seen in IDLE at cycle 0:
  - KE: issue at cycle 1; ke_wr_en and ke_done at 1+SBOX_LAT.
  - DP: issues at cycles 1..4; dp_wr_en at 1+L..4+L with cols 0..3; dp_done at 4+L.
  - The state is IDLE at done+1.
- Requester protocol: deassert req on the edge where done is sampled high. A req still high in IDLE at done+1 is treated as a new request.
- Outside active operations, col_sel=0 and sbox_src_sel=0.
- Dropping req mid-operation does not abort; the operation completes normally.

Optional Feature:
Macro AES_SBOX_ARB_PROTO_CHECK_EN.
- Defined: proto_err is set and held until reset by either condition:
  - the owning requester's req drops while busy and before its done;
  - a done pulse fires while the owner's req is already low.
- Not defined: proto_err is tied to 0 and no check logic is built. Port list is unchanged.

Test Plan:
1. SBOX_LAT=2, dp_req high at cycle 0 -> sbox_issue cycles 1-4 with col_sel 0,1,2,3 and src_sel 0; dp_wr_en cycles 3-6 with dp_wr_col 0,1,2,3; dp_done at cycle 6 only; busy cycles 1-6.
2. SBOX_LAT=2, ke_req alone at cycle 0 -> sbox_issue cycle 1 with src_sel=1; ke_wr_en and ke_done at cycle 3; no dp_wr_en at any point.
3. KEY_PRIORITY=1, SBOX_LAT=2, both reqs high at cycle 0, each dropped after its done -> ke_done cycle 3; DP issues cycles 5-8; dp_done cycle 10.
4. KEY_PRIORITY=0, SBOX_LAT=1, both reqs re-raised immediately after each done -> grant order KE, DP, KE, DP with no double grant; each op's wr_en count correct (1 or 4).
5. SBOX_LAT=3, DP op with reset asserted at cycle 3 -> cycle 4 all outputs 0; no dp_done. A subsequent dp_req issues col_sel 0 first, with full 4-column completion.
6. Macro defined, dp_req dropped at cycle 2 -> proto_err=1 from cycle 3, held across later ops until reset; op still gives 4 wr_en and dp_done. Macro undefined, same stimulus -> proto_err stays 0.
